mixer_lo_gen: RTL

- Parametrised successor to the single-channel LO control in the mixer top level.
- Generates registered, complementary, break-before-make LO drive pairs (lo_p/lo_n) for up to two Gilbert-cell mixer cores.
- The internal source is a programmable divider with I/Q (90 deg) channel offset and programmable dead time.
- An external LO passthrough path is provided, with glitch-free switching between sources at period boundaries.

---
 rtl/mixer_lo_gen.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mixer_lo_gen.sv
// mixer_lo_gen
//   Generates complementary, break-before-make LO drive pairs for one or two
//   Gilbert-cell mixer cores. The internal source is a divide-by-4N phase
//   counter. Channel 1, when present, lags channel 0 by a quarter period (Q).
//   Each half-period begins with a programmable dead time. The LO can also
//   come from an external pin pair. Source changes and config changes take
//   effect only at a period boundary, through a one-cycle all-low break.
//
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   lo_en         1 = LO running, 0 = outputs parked low
//   ext_lo_en     1 = external LO passthrough, 0 = internal divider
//   ext_lo_p/n    external LO phases (asynchronous pins)
//   div_ratio     quarter-period length N (0 behaves as 1)
//   dead_cycles   non-overlap cycles D at the start of each half-period
//   cfg_load      pulse that latches div_ratio/dead_cycles into the shadow
//   cfg_busy      a shadow value is waiting to be applied
//   lo_p, lo_n    registered LO drive per channel
//   locked        output is a stable, fully configured LO
module mixer_lo_gen #(
  parameter int DIV_W  = 8,
  parameter int DEAD_W = 3,
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lo_en,
  input  logic              ext_lo_en,
  input  logic              ext_lo_p,
  input  logic              ext_lo_n,
  input  logic [DIV_W-1:0]  div_ratio,
  input  logic [DEAD_W-1:0] dead_cycles,
  input  logic              cfg_load,
  output logic              cfg_busy,
  output logic [NUM_CH-1:0] lo_p,
  output logic [NUM_CH-1:0] lo_n,
  output logic              locked
);

  // The counter spans 0..4N-1, which needs two bits more than N.
  localparam int CW = DIV_W + 2;

  typedef enum logic [1:0] {IDLE, BRK, RUN, EXT} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DIV_W-1:0]  n_act;
  logic [DIV_W-1:0]  n_shd;
  logic [DEAD_W-1:0] d_act;
  logic [DEAD_W-1:0] d_shd;
  logic              ext_p_sync_p0;
  logic              ext_p_sync_p1;
  logic              ext_n_sync_p0;
  logic              ext_n_sync_p1;
  logic [1:0]        ext_res;
  logic [CW-1:0]     last_cnt;
  logic [CW-1:0]     deff;
  logic              apply;
  logic [1:0]        drv [NUM_CH];

  // Clamp the dead time to H-1, so every phase is high for at least one cycle.
  function automatic logic [CW-1:0] dead_sat(input logic [DIV_W-1:0]  n,
                                             input logic [DEAD_W-1:0] d);
    logic [CW-1:0] lim;
    logic [CW-1:0] dw;
    lim = {1'b0, n, 1'b0} - CW'(1);
    dw  = CW'(d);
    dead_sat = (dw > lim) ? lim : dw;
  endfunction

  // Returns {p, n} for a channel whose period starts at counter value 'off'.
  // The wrap addition is taken modulo 2^CW. The true result is below 4N, so
  // it cannot alias.
  function automatic logic [1:0] phase_drv(input logic [CW-1:0]    c,
                                           input logic [DIV_W-1:0] n,
                                           input logic [CW-1:0]    off,
                                           input logic [CW-1:0]    dt);
    logic [CW-1:0] per;
    logic [CW-1:0] half;
    logic [CW-1:0] rel;
    logic [CW-1:0] pos;
    logic          act;
    per  = {n, 2'b00};
    half = {1'b0, n, 1'b0};
    rel  = (c >= off) ? c - off : c + per - off;
    act  = rel < half;
    pos  = act ? rel : rel - half;
    phase_drv = {act && (pos >= dt), !act && (pos >= dt)};
  endfunction

  // 4N-1 written as {N-1, 2'b11}. It cannot overflow because N >= 1.
  assign last_cnt = {n_act - DIV_W'(1), 2'b11};
  assign deff     = dead_sat(n_act, d_act);

  // A pending config is applied on any edge outside RUN. From RUN it is
  // applied only after the period ends and the FSM passes through BRK.
  assign apply    = cfg_busy && (state != RUN);

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      drv[k] = phase_drv(cnt, n_act, (k == 1) ? {2'b00, n_act} : CW'(0), deff);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      n_act         <= DIV_W'(1);
      d_act         <= '0;
      cfg_busy      <= 1'b0;
      ext_p_sync_p0 <= 1'b0;
      ext_p_sync_p1 <= 1'b0;
      ext_n_sync_p0 <= 1'b0;
      ext_n_sync_p1 <= 1'b0;
      ext_res       <= '0;
      lo_p          <= '0;
      lo_n          <= '0;
      locked        <= 1'b0;
    end else begin
      // ---- stage p0/p1: two-flop synchronisers on the external LO pins ----
      ext_p_sync_p0 <= ext_lo_p;
      ext_p_sync_p1 <= ext_p_sync_p0;
      ext_n_sync_p0 <= ext_lo_n;
      ext_n_sync_p1 <= ext_n_sync_p0;

      // ---- shadow / active configuration ----
      // A load on the same edge as an apply keeps cfg_busy high. The newer
      // value then waits for the next apply opportunity.
      if (apply) begin
        n_act <= n_shd;
        d_act <= d_shd;
      end
      if (cfg_load) begin
        cfg_busy <= 1'b1;
      end else if (apply) begin
        cfg_busy <= 1'b0;
      end

      // ---- source FSM ----
      case (state)
        IDLE: if (lo_en) state <= BRK;
        BRK: begin
          if (!lo_en) begin
            state <= IDLE;
          end else if (ext_lo_en) begin
            state <= EXT;
          end else begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (cnt == last_cnt) begin
            cnt <= '0;
            if (!lo_en || ext_lo_en || cfg_busy) state <= BRK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        EXT: if (!lo_en || !ext_lo_en) state <= BRK;
        default: state <= IDLE;
      endcase

      // EXT residency counter, saturating at 3.
      if (state == EXT) begin
        ext_res <= (ext_res == 2'd3) ? 2'd3 : ext_res + 2'd1;
      end else begin
        ext_res <= '0;
      end

      // ---- stage p2: registered drive outputs ----
      lo_p <= '0;
      lo_n <= '0;
      if (state == RUN) begin
        for (int k = 0; k < NUM_CH; k++) begin
          lo_p[k] <= drv[k][1];
          lo_n[k] <= drv[k][0];
        end
      end else if (state == EXT) begin
        // Both pins high at once would overlap the drive, so park both low.
        lo_p[0] <= ext_p_sync_p1 & ~ext_n_sync_p1;
        lo_n[0] <= ext_n_sync_p1 & ~ext_p_sync_p1;
      end
      locked <= ((state == RUN) && !cfg_busy) || ((state == EXT) && (ext_res >= 2'd2));
    end
  end

  // Shadow registers are data only and need no reset. cfg_busy gates their use.
  always_ff @(posedge clk) begin
    if (cfg_load) begin
      n_shd <= (div_ratio == '0) ? DIV_W'(1) : div_ratio;
      d_shd <= dead_cycles;
    end
  end

endmodule
